// File: rtl/keypad_scan_ctrl_if.sv
// Key-event handshake between the keypad scanner (master) and its consumer (slave).
interface keypad_scan_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       key_held;
    logic       overrun;

    modport master (
        output key_valid,
        output key_code,
        output key_held,
        output overrun,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  key_held,
        input  overrun,
        output key_ready
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with full-scan debounce and single-shot key events.
// States: DRIVE | column held low while rows settle; SAMPLE | rows latched, column advances.
module keypad_scan_ctrl #(
    parameter int SETTLE_CYCLES  = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                Row,
    output logic [3:0]                Col,
    keypad_scan_ctrl_if.master        key_if
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_SCANS);
    // bit 4 set marks "no single key" so it never collides with a real code
    localparam logic [4:0]       NONE     = 5'h10;

    typedef enum logic {DRIVE, SAMPLE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;
    logic [3:0]       slot0_q, slot0_d;
    logic [3:0]       slot1_q, slot1_d;
    logic [3:0]       slot2_q, slot2_d;
    logic [4:0]       prev_q, prev_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [4:0]       stable_q, stable_d;
    logic             valid_q, valid_d;
    logic [3:0]       code_q, code_d;
    logic             overrun_q, overrun_d;
    logic             held_q, held_d;

    logic [15:0]      all_rows;
    logic [4:0]       low_cnt;
    logic [3:0]       hit_code;
    logic [4:0]       scan_res;
    logic             event_new;

    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h4;
            4'd2:    code = 4'h7;
            4'd3:    code = 4'hF;
            4'd4:    code = 4'h2;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h8;
            4'd7:    code = 4'h0;
            4'd8:    code = 4'h3;
            4'd9:    code = 4'h6;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hE;
            4'd12:   code = 4'hA;
            4'd13:   code = 4'hB;
            4'd14:   code = 4'hC;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // C4 is evaluated in its own SAMPLE cycle, so it uses the live rows
    assign all_rows = {slot0_q, slot1_q, slot2_q, Row};

    always_comb begin
        low_cnt  = '0;
        hit_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (!all_rows[15-i]) begin
                low_cnt  = low_cnt + 5'd1;
                hit_code = key_map(4'(i));
            end
        end
        scan_res = (low_cnt == 5'd1) ? {1'b0, hit_code} : NONE;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_idx_d = col_idx_q;
        col_d     = col_q;
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        slot2_d   = slot2_q;
        prev_d    = prev_q;
        db_cnt_d  = db_cnt_q;
        stable_d  = stable_q;
        held_d    = held_q;
        valid_d   = valid_q;
        code_d    = code_q;
        overrun_d = overrun_q;
        event_new = 1'b0;

        case (state_q)
            DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                state_d   = DRIVE;
                col_idx_d = col_idx_q + 2'd1;
                col_d     = {col_q[0], col_q[3:1]};
                case (col_idx_q)
                    2'd0: slot0_d = Row;
                    2'd1: slot1_d = Row;
                    2'd2: slot2_d = Row;
                    default: begin
                        if (scan_res == prev_q) begin
                            db_cnt_d = (db_cnt_q == DB_MAX) ? DB_MAX : db_cnt_q + DB_W'(1);
                        end else begin
                            db_cnt_d = DB_W'(1);
                        end
                        prev_d = scan_res;
                        if ((db_cnt_d == DB_MAX) && (scan_res != stable_q)) begin
                            stable_d  = scan_res;
                            held_d    = (scan_res != NONE);
                            event_new = (scan_res != NONE);
                        end
                    end
                endcase
            end
            default: state_d = DRIVE;
        endcase

        // an accept in the same cycle frees the slot for the new event
        if (event_new) begin
            if (!valid_q || key_if.key_ready) begin
                valid_d = 1'b1;
                code_d  = scan_res[3:0];
            end else begin
                overrun_d = 1'b1;
            end
        end else if (key_if.key_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DRIVE;
            cnt_q     <= '0;
            col_idx_q <= 2'd0;
            col_q     <= 4'b0111;
            slot0_q   <= 4'hF;
            slot1_q   <= 4'hF;
            slot2_q   <= 4'hF;
            prev_q    <= NONE;
            db_cnt_q  <= '0;
            stable_q  <= NONE;
            held_q    <= 1'b0;
            valid_q   <= 1'b0;
            code_q    <= 4'h0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            slot2_q   <= slot2_d;
            prev_q    <= prev_d;
            db_cnt_q  <= db_cnt_d;
            stable_q  <= stable_d;
            held_q    <= held_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            overrun_q <= overrun_d;
        end
    end

    assign Col              = col_q;
    assign key_if.key_valid = valid_q;
    assign key_if.key_code  = code_q;
    assign key_if.key_held  = held_q;
    assign key_if.overrun   = overrun_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: ideal keypad matrix plus a scan-level model of debounce and handshake.
module tb_keypad_scan_ctrl;
    localparam int SETTLE = 8;
    localparam int DB     = 2;
    localparam int SCAN   = 4 * (SETTLE + 1);
    localparam int NONE   = -1;
    localparam int K1 = 0, K7 = 2, K2 = 4, K5 = 5, K3 = 8, K9 = 10, KD = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] mask = '0;

    int errors = 0;
    int checks = 0;
    int accepts = 0;

    logic [3:0] keymap [16] = '{4'h1, 4'h4, 4'h7, 4'hF, 4'h2, 4'h5, 4'h8, 4'h0,
                                4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};

    int         m_prev, m_cnt, m_stable;
    bit         m_valid, m_overrun;
    logic [3:0] m_code;

    keypad_scan_ctrl_if kif();

    keypad_scan_ctrl #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DB)) dut (
        .clk    (clk),
        .rst    (rst),
        .Row    (row),
        .Col    (col),
        .key_if (kif)
    );

    always #5 clk = ~clk;

    // ideal keypad: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!col[3-c])
                for (int r = 0; r < 4; r++)
                    if (mask[c*4+r]) row[3-r] = 1'b0;
    end

    always @(posedge clk)
        if (!rst && kif.key_valid && kif.key_ready) accepts <= accepts + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    function automatic logic [15:0] key_bit(input int k);
        logic [15:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic int scan_result(input logic [15:0] m);
        int n, k;
        n = 0;
        k = 0;
        for (int i = 0; i < 16; i++) if (m[i]) begin n++; k = i; end
        return (n == 1) ? int'(keymap[k]) : NONE;
    endfunction

    function automatic logic [6:0] exp_status();
        return {m_valid, m_valid ? m_code : 4'h0, m_stable != NONE, m_overrun};
    endfunction

    function automatic logic [6:0] got_status();
        return {kif.key_valid, kif.key_valid ? kif.key_code : 4'h0, kif.key_held, kif.overrun};
    endfunction

    task automatic model_reset();
        m_prev = NONE; m_cnt = 0; m_stable = NONE;
        m_valid = 0; m_code = 4'h0; m_overrun = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // one full scan with a fixed key set and ready level, then advance the model
    task automatic run_scan(input logic [15:0] m, input bit rdy);
        int res;
        bit ev;
        mask = m;
        kif.key_ready = rdy;
        repeat (SCAN) @(posedge clk);
        #1;
        res = scan_result(m);
        if (res == m_prev) m_cnt = (m_cnt + 1 > DB) ? DB : m_cnt + 1;
        else m_cnt = 1;
        m_prev = res;
        ev = 0;
        if (m_cnt == DB && res != m_stable) begin
            m_stable = res;
            ev = (res != NONE);
        end
        if (rdy) begin
            m_valid = ev;
            if (ev) m_code = 4'(res);
        end else if (ev) begin
            if (!m_valid) begin m_valid = 1; m_code = 4'(res); end
            else m_overrun = 1;
        end
    endtask

    task automatic test_reset();
        logic [3:0] ec;
        mask = '0;
        kif.key_ready = 1'b0;
        do_reset();
        checks++;
        if (got_status() !== 7'b0 || kif.key_code !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %b code %h want 0000000 code 0", got_status(), kif.key_code);
        end
        for (int i = 0; i < 2 * SCAN + 4; i++) begin
            ec = 4'b1000 >> ((i / (SETTLE + 1)) % 4);
            checks++;
            if (col !== ~ec) begin
                errors++;
                $display("FAIL reset_col cycle %0d: got %b want %b", i, col, ~ec);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_press_release();
        int base;
        do_reset();
        base = accepts;
        for (int s = 0; s < 8; s++) begin
            run_scan((s < 5) ? key_bit(K5) : 16'h0, 1'b1);
            checks++;
            if (got_status() !== exp_status()) begin
                errors++;
                $display("FAIL press5 scan %0d: got %b want %b", s, got_status(), exp_status());
            end
        end
        checks++;
        if (accepts - base !== 1) begin
            errors++;
            $display("FAIL press5_events: got %0d want 1", accepts - base);
        end
    endtask

    task automatic test_hold_no_ready();
        do_reset();
        for (int s = 0; s < 10; s++) begin
            run_scan(key_bit(KD), 1'b0);
            checks++;
            if (got_status() !== exp_status()) begin
                errors++;
                $display("FAIL holdD scan %0d: got %b want %b", s, got_status(), exp_status());
            end
        end
        kif.key_ready = 1'b1;
        @(posedge clk);
        #1 kif.key_ready = 1'b0;
        checks++;
        if (kif.key_valid !== 1'b0 || kif.key_held !== 1'b1) begin
            errors++;
            $display("FAIL holdD_accept: got valid %b held %b want valid 0 held 1", kif.key_valid, kif.key_held);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] seq [9];
        seq = '{key_bit(K1), key_bit(K1), key_bit(K1), 16'h0, 16'h0, 16'h0,
                key_bit(K9), key_bit(K9), key_bit(K9)};
        do_reset();
        for (int s = 0; s < 9; s++) begin
            run_scan(seq[s], 1'b0);
            checks++;
            if (got_status() !== exp_status()) begin
                errors++;
                $display("FAIL overrun scan %0d: got %b want %b", s, got_status(), exp_status());
            end
        end
        checks++;
        if (kif.overrun !== 1'b1 || kif.key_code !== 4'h1) begin
            errors++;
            $display("FAIL overrun_final: got ovr %b code %h want ovr 1 code 1", kif.overrun, kif.key_code);
        end
    endtask

    task automatic test_bounce();
        int base;
        logic [15:0] seq [7];
        seq = '{key_bit(K7), 16'h0, key_bit(K7), 16'h0, key_bit(K7), key_bit(K7), key_bit(K7)};
        do_reset();
        base = accepts;
        for (int s = 0; s < 7; s++) begin
            run_scan(seq[s], 1'b1);
            checks++;
            if (got_status() !== exp_status()) begin
                errors++;
                $display("FAIL bounce7 scan %0d: got %b want %b", s, got_status(), exp_status());
            end
        end
        checks++;
        if (accepts - base !== 1) begin
            errors++;
            $display("FAIL bounce7_events: got %0d want 1", accepts - base);
        end
    endtask

    task automatic test_two_keys_and_reset();
        do_reset();
        for (int s = 0; s < 5; s++) begin
            run_scan((s < 3) ? (key_bit(K2) | key_bit(K3)) : key_bit(K2), 1'b0);
            checks++;
            if (got_status() !== exp_status()) begin
                errors++;
                $display("FAIL twokeys scan %0d: got %b want %b", s, got_status(), exp_status());
            end
        end
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (kif.key_valid !== 1'b0 || col !== 4'b0111 || kif.key_held !== 1'b0 || kif.overrun !== 1'b0) begin
            errors++;
            $display("FAIL midscan_rst: got valid %b col %b held %b ovr %b want 0 0111 0 0",
                     kif.key_valid, col, kif.key_held, kif.overrun);
        end
        rst = 1'b0;
        model_reset();
        for (int s = 0; s < 2; s++) begin
            run_scan(key_bit(K2), 1'b0);
            checks++;
            if (got_status() !== exp_status()) begin
                errors++;
                $display("FAIL rereport scan %0d: got %b want %b", s, got_status(), exp_status());
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] m, prev_m;
        int kind, a, b;
        do_reset();
        prev_m = '0;
        for (int s = 0; s < 40; s++) begin
            kind = $urandom_range(0, 5);
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            case (kind)
                0:       m = '0;
                1:       m = key_bit(a) | key_bit(b);
                2, 3:    m = prev_m;
                default: m = key_bit(a);
            endcase
            prev_m = m;
            run_scan(m, 1'($urandom_range(0, 1)));
            checks++;
            if (got_status() !== exp_status()) begin
                errors++;
                $display("FAIL random scan %0d mask %h: got %b want %b", s, m, got_status(), exp_status());
            end
        end
    endtask

    initial begin
        kif.key_ready = 1'b0;
        model_reset();
        test_reset();
        test_press_release();
        test_hold_no_ready();
        test_overrun();
        test_bounce();
        test_two_keys_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
